// File: rtl/cpu_result_checker.sv
// Self-checker that sits beside the CPU and compares num_inst/output_port against a loadable expected table.
// Define CPU_RESULT_CHECKER_TRACE_EN to add first-failure capture ports (observed, expected, num_inst).
module cpu_result_checker #(
   parameter int WORD_SIZE    = 16,
   parameter int NUM_TEST     = 56,
   parameter int IDX_W        = 6,
   parameter int CYC_W        = 16,
   parameter int MAX_CYCLES   = 10000,
   parameter int STOP_ON_FAIL = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 load_valid,
   input  logic [WORD_SIZE-1:0] load_inst,
   input  logic [WORD_SIZE-1:0] load_ans,
   output logic                 load_ready,
   input  logic                 start,
   input  logic [WORD_SIZE-1:0] num_inst,
   input  logic [WORD_SIZE-1:0] output_port,
   input  logic                 is_halted,
   output logic                 busy,
   output logic                 done,
   output logic [1:0]           done_cause,
   output logic                 all_pass,
   output logic [IDX_W-1:0]     pass_cnt,
   output logic [IDX_W-1:0]     fail_cnt,
   output logic [IDX_W-1:0]     miss_cnt,
   output logic                 first_fail_vld,
   output logic [IDX_W-1:0]     first_fail_idx,
   output logic [CYC_W-1:0]     cycle_cnt,
`ifdef CPU_RESULT_CHECKER_TRACE_EN
   output logic [WORD_SIZE-1:0] first_fail_got,
   output logic [WORD_SIZE-1:0] first_fail_exp,
   output logic [WORD_SIZE-1:0] first_fail_inst,
`endif
   output logic                 cfg_err
);

   // state | meaning
   // IDLE  | table may be loaded; waiting for start
   // RUN   | comparing the CPU against entry[rd_ptr] every cycle
   // DONE  | run finished; results held until start or reset
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam int                TBL_AW     = (NUM_TEST > 1) ? $clog2(NUM_TEST) : 1;
   localparam logic [IDX_W-1:0]  NUM_TEST_C = IDX_W'(NUM_TEST);
   localparam logic [CYC_W:0]    MAX_C      = (CYC_W+1)'(MAX_CYCLES);

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     entries_q, entries_d, rd_ptr_q, rd_ptr_d;
   logic [IDX_W-1:0]     pass_q, pass_d, fail_q, fail_d, miss_q, miss_d, ffi_q, ffi_d;
   logic                 ffv_q, ffv_d, cfg_err_q, cfg_err_d;
   logic [CYC_W-1:0]     cycle_q, cycle_d;
   logic [1:0]           cause_q, cause_d;
   logic [WORD_SIZE-1:0] last_inst_q, last_inst_d;
`ifdef CPU_RESULT_CHECKER_TRACE_EN
   logic [WORD_SIZE-1:0] ff_got_q, ff_got_d, ff_exp_q, ff_exp_d, ff_inst_q, ff_inst_d;
`endif

   logic [WORD_SIZE-1:0] tbl_inst_q [NUM_TEST];
   logic [WORD_SIZE-1:0] tbl_ans_q  [NUM_TEST];

   logic [WORD_SIZE-1:0] cur_inst, cur_ans;
   logic [IDX_W-1:0]     rd_ptr_nxt;
   logic                 run, hit, past, retire, pass_now, fail_now, miss_now, all_chk, timeout;
   logic                 load_fire, load_ok, start_go, term_vld;
   logic [1:0]           term_cause;

   assign run        = (state_q == S_RUN);
   assign cur_inst   = tbl_inst_q[rd_ptr_q[TBL_AW-1:0]];
   assign cur_ans    = tbl_ans_q[rd_ptr_q[TBL_AW-1:0]];
   assign hit        = (num_inst == cur_inst);
   assign past       = (num_inst > cur_inst);
   assign retire     = run && (hit || past);
   assign pass_now   = run && hit && (output_port == cur_ans);
   assign fail_now   = run && hit && (output_port != cur_ans);
   assign miss_now   = run && past;
   assign rd_ptr_nxt = rd_ptr_q + IDX_W'(1);
   assign all_chk    = retire && (rd_ptr_nxt == entries_q);
   assign timeout    = (({1'b0, cycle_q} + (CYC_W+1)'(1)) == MAX_C);
   assign load_fire  = load_valid && load_ready;
   // The first entry has no predecessor, so it is always accepted.
   assign load_ok    = load_fire && ((entries_q == '0) || (load_inst > last_inst_q));
   assign start_go   = start && (state_q != S_RUN);

   always_comb begin
      term_vld   = 1'b0;
      term_cause = 2'b00;
      if (run) begin
         if ((STOP_ON_FAIL != 0) && fail_now) begin
            term_vld   = 1'b1;
            term_cause = 2'b11;
         end else if (all_chk) begin
            term_vld   = 1'b1;
            term_cause = 2'b00;
         end else if (is_halted) begin
            term_vld   = 1'b1;
            term_cause = 2'b01;
         end else if (timeout) begin
            term_vld   = 1'b1;
            term_cause = 2'b10;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_DONE: if (start) state_d = (entries_q == '0) ? S_DONE : S_RUN;
         S_RUN:          if (term_vld) state_d = S_DONE;
         default:        state_d = S_IDLE;
      endcase
   end

   always_comb begin
      load_ready = (state_q == S_IDLE) && (entries_q < NUM_TEST_C);
      busy       = run;
      done       = (state_q == S_DONE);
      all_pass   = done && (fail_q == '0) && (pass_q == entries_q) && (entries_q != '0);
   end

   always_comb begin
      entries_d   = entries_q;
      last_inst_d = last_inst_q;
      cfg_err_d   = cfg_err_q;
      rd_ptr_d    = rd_ptr_q;
      pass_d      = pass_q;
      fail_d      = fail_q;
      miss_d      = miss_q;
      ffv_d       = ffv_q;
      ffi_d       = ffi_q;
      cycle_d     = cycle_q;
      cause_d     = cause_q;
`ifdef CPU_RESULT_CHECKER_TRACE_EN
      ff_got_d    = ff_got_q;
      ff_exp_d    = ff_exp_q;
      ff_inst_d   = ff_inst_q;
`endif
      if (load_ok) begin
         entries_d   = entries_q + IDX_W'(1);
         last_inst_d = load_inst;
      end else if (load_fire) begin
         cfg_err_d = 1'b1;
      end
      if (start_go) begin
         rd_ptr_d = '0;
         pass_d   = '0;
         fail_d   = '0;
         miss_d   = '0;
         ffv_d    = 1'b0;
         ffi_d    = '0;
         cycle_d  = '0;
         cause_d  = 2'b00;
`ifdef CPU_RESULT_CHECKER_TRACE_EN
         ff_got_d  = '0;
         ff_exp_d  = '0;
         ff_inst_d = '0;
`endif
      end
      if (run) begin
         if (cycle_q != '1) cycle_d = cycle_q + CYC_W'(1);
         if (pass_now) pass_d = pass_q + IDX_W'(1);
         if (miss_now) miss_d = miss_q + IDX_W'(1);
         if (fail_now) begin
            fail_d = fail_q + IDX_W'(1);
            if (!ffv_q) begin
               ffv_d = 1'b1;
               ffi_d = rd_ptr_q;
`ifdef CPU_RESULT_CHECKER_TRACE_EN
               ff_got_d  = output_port;
               ff_exp_d  = cur_ans;
               ff_inst_d = num_inst;
`endif
            end
         end
         if (retire)   rd_ptr_d = rd_ptr_nxt;
         if (term_vld) cause_d  = term_cause;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         entries_q   <= '0;
         last_inst_q <= '0;
         cfg_err_q   <= 1'b0;
         rd_ptr_q    <= '0;
         pass_q      <= '0;
         fail_q      <= '0;
         miss_q      <= '0;
         ffv_q       <= 1'b0;
         ffi_q       <= '0;
         cycle_q     <= '0;
         cause_q     <= 2'b00;
`ifdef CPU_RESULT_CHECKER_TRACE_EN
         ff_got_q    <= '0;
         ff_exp_q    <= '0;
         ff_inst_q   <= '0;
`endif
      end else begin
         entries_q   <= entries_d;
         last_inst_q <= last_inst_d;
         cfg_err_q   <= cfg_err_d;
         rd_ptr_q    <= rd_ptr_d;
         pass_q      <= pass_d;
         fail_q      <= fail_d;
         miss_q      <= miss_d;
         ffv_q       <= ffv_d;
         ffi_q       <= ffi_d;
         cycle_q     <= cycle_d;
         cause_q     <= cause_d;
`ifdef CPU_RESULT_CHECKER_TRACE_EN
         ff_got_q    <= ff_got_d;
         ff_exp_q    <= ff_exp_d;
         ff_inst_q   <= ff_inst_d;
`endif
      end
   end

   // Table contents need no reset: entries_q gates every read.
   always_ff @(posedge clk) begin
      if (load_ok) begin
         tbl_inst_q[entries_q[TBL_AW-1:0]] <= load_inst;
         tbl_ans_q[entries_q[TBL_AW-1:0]]  <= load_ans;
      end
   end

   assign done_cause     = cause_q;
   assign pass_cnt       = pass_q;
   assign fail_cnt       = fail_q;
   assign miss_cnt       = miss_q;
   assign first_fail_vld = ffv_q;
   assign first_fail_idx = ffi_q;
   assign cycle_cnt      = cycle_q;
   assign cfg_err        = cfg_err_q;
`ifdef CPU_RESULT_CHECKER_TRACE_EN
   assign first_fail_got  = ff_got_q;
   assign first_fail_exp  = ff_exp_q;
   assign first_fail_inst = ff_inst_q;
`endif

endmodule

// File: tb/tb_cpu_result_checker.sv
// Scoreboard bench for cpu_result_checker: each run pushes its expected summary, a monitor checks it when done rises.
module tb_cpu_result_checker;
   localparam int W = 16;
   localparam int IW = 6;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          load_valid = 1'b0;
   logic [W-1:0]  load_inst = '0, load_ans = '0;
   logic          load_ready;
   logic          start = 1'b0;
   logic [W-1:0]  num_inst = '0, output_port = '0;
   logic          is_halted = 1'b0;
   logic          busy, done, all_pass, first_fail_vld, cfg_err;
   logic [1:0]    done_cause;
   logic [IW-1:0] pass_cnt, fail_cnt, miss_cnt, first_fail_idx;
   logic [CW-1:0] cycle_cnt;
`ifdef CPU_RESULT_CHECKER_TRACE_EN
   logic [W-1:0]  first_fail_got, first_fail_exp, first_fail_inst;
`endif

   always #5 clk = ~clk;

   cpu_result_checker #(
      .WORD_SIZE(W), .NUM_TEST(4), .IDX_W(IW), .CYC_W(CW), .MAX_CYCLES(20), .STOP_ON_FAIL(1)
   ) dut (
      .clk(clk), .reset_n(reset_n), .load_valid(load_valid), .load_inst(load_inst),
      .load_ans(load_ans), .load_ready(load_ready), .start(start), .num_inst(num_inst),
      .output_port(output_port), .is_halted(is_halted), .busy(busy), .done(done),
      .done_cause(done_cause), .all_pass(all_pass), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
      .miss_cnt(miss_cnt), .first_fail_vld(first_fail_vld), .first_fail_idx(first_fail_idx),
      .cycle_cnt(cycle_cnt),
`ifdef CPU_RESULT_CHECKER_TRACE_EN
      .first_fail_got(first_fail_got), .first_fail_exp(first_fail_exp),
      .first_fail_inst(first_fail_inst),
`endif
      .cfg_err(cfg_err)
   );

   typedef struct {
      logic [1:0]    cause;
      logic [IW-1:0] pass, fail, miss, ffi;
      logic          ffv, ap;
      logic [CW-1:0] cyc;
      logic [W-1:0]  got, exp_ans, inst;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   logic done_prev = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic push(input logic [1:0] cause, input int p, input int f, input int m,
                       input logic ffv, input int ffi, input logic ap, input int cyc,
                       input int got, input int ea, input int inst);
      exp_t e;
      e.cause = cause; e.pass = IW'(p); e.fail = IW'(f); e.miss = IW'(m);
      e.ffv = ffv; e.ffi = IW'(ffi); e.ap = ap; e.cyc = CW'(cyc);
      e.got = W'(got); e.exp_ans = W'(ea); e.inst = W'(inst);
      sb.push_back(e);
   endtask

   // Monitor: checks one scoreboard entry per rising edge of done.
   always @(negedge clk) begin
      if (!reset_n) begin
         done_prev = 1'b0;
      end else begin
         if (done && !done_prev) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 32'(done), 32'(0));
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("done_cause", 32'(done_cause), 32'(e.cause));
               chk("pass_cnt", 32'(pass_cnt), 32'(e.pass));
               chk("fail_cnt", 32'(fail_cnt), 32'(e.fail));
               chk("miss_cnt", 32'(miss_cnt), 32'(e.miss));
               chk("first_fail_vld", 32'(first_fail_vld), 32'(e.ffv));
               chk("first_fail_idx", 32'(first_fail_idx), 32'(e.ffi));
               chk("all_pass", 32'(all_pass), 32'(e.ap));
               chk("cycle_cnt", 32'(cycle_cnt), 32'(e.cyc));
               chk("busy_in_done", 32'(busy), 32'(0));
`ifdef CPU_RESULT_CHECKER_TRACE_EN
               chk("first_fail_got", 32'(first_fail_got), 32'(e.got));
               chk("first_fail_exp", 32'(first_fail_exp), 32'(e.exp_ans));
               chk("first_fail_inst", 32'(first_fail_inst), 32'(e.inst));
`endif
            end
         end
         done_prev = done;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int inst, input int ans);
      load_valid = 1'b1;
      load_inst  = W'(inst);
      load_ans   = W'(ans);
      tick();
      load_valid = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic step(input int n, input int op, input logic h);
      num_inst    = W'(n);
      output_port = W'(op);
      is_halted   = h;
      tick();
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && !done; i++) tick();
      chk("done_reached", 32'(done), 32'(1));
      @(negedge clk);
      #1;
   endtask

   task automatic prep();
      num_inst    = '0;
      output_port = '0;
      is_halted   = 1'b0;
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      reset_n = 1'b0;
      #3;
      chk("rst_load_ready", 32'(load_ready), 32'(1));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_pass_cnt", 32'(pass_cnt), 32'(0));
      chk("rst_cycle_cnt", 32'(cycle_cnt), 32'(0));
      chk("rst_cfg_err", 32'(cfg_err), 32'(0));
      chk("rst_all_pass", 32'(all_pass), 32'(0));
      @(negedge clk);
      reset_n = 1'b1;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      #12;
      chk("init_load_ready", 32'(load_ready), 32'(1));
      chk("init_done_cause", 32'(done_cause), 32'(0));
      chk("init_first_fail", 32'(first_fail_vld), 32'(0));
      @(negedge clk);
      reset_n = 1'b1;
      #1;

      // Empty table: straight to DONE, all_pass stays 0.
      push(2'b00, 0, 0, 0, 1'b0, 0, 1'b0, 0, 0, 0, 0);
      do_start();
      wait_done(3);
      reset_pulse();

      load(3, 0);
      load(5, 0);
      load(11, 1);

      // All entries match.
      prep();
      push(2'b00, 3, 0, 0, 1'b0, 0, 1'b1, 12, 0, 0, 0);
      do_start();
      chk("busy_in_run", 32'(busy), 32'(1));
      for (int n = 0; n <= 11; n++) step(n, (n >= 11) ? 1 : 0, 1'b0);
      wait_done(5);

      // Loads outside IDLE must be ignored; an extra entry would stall the miss run.
      chk("load_ready_done", 32'(load_ready), 32'(0));
      load(20, 0);

      // Mismatch at num_inst=5 stops the run.
      prep();
      push(2'b11, 1, 1, 0, 1'b1, 1, 1'b0, 6, 2, 0, 5);
      do_start();
      for (int n = 0; n <= 5; n++) step(n, (n == 5) ? 2 : 0, 1'b0);
      wait_done(5);

      // Jump past two entries: they retire as misses on consecutive cycles.
      prep();
      push(2'b00, 1, 0, 2, 1'b0, 0, 1'b0, 6, 0, 0, 0);
      do_start();
      step(0, 0, 1'b0);
      step(1, 0, 1'b0);
      step(2, 0, 1'b0);
      step(3, 0, 1'b0);
      step(12, 0, 1'b0);
      step(12, 0, 1'b0);
      wait_done(5);

      // Halt at num_inst=5 after entry 1 is checked.
      prep();
      push(2'b01, 2, 0, 0, 1'b0, 0, 1'b0, 6, 0, 0, 0);
      do_start();
      for (int n = 0; n <= 5; n++) step(n, 0, n == 5);
      wait_done(5);
      is_halted = 1'b0;

      // Reset in the middle of a run.
      prep();
      do_start();
      for (int n = 0; n <= 3; n++) step(n, 0, 1'b0);
      chk("mid_run_pass_cnt", 32'(pass_cnt), 32'(1));
      reset_pulse();

      // Non-ascending load rejected; table fills to 4 entries only after three more.
      load(5, 0);
      load(5, 0);
      chk("cfg_err_set", 32'(cfg_err), 32'(1));
      load(6, 0);
      load(7, 0);
      chk("load_ready_3", 32'(load_ready), 32'(1));
      load(8, 0);
      chk("load_ready_full", 32'(load_ready), 32'(0));

      // num_inst stuck at 0: timeout after 20 RUN cycles.
      prep();
      push(2'b10, 0, 0, 0, 1'b0, 0, 1'b0, 20, 0, 0, 0);
      do_start();
      for (int i = 0; i < 18; i++) tick();
      chk("no_early_timeout", 32'(done), 32'(0));
      wait_done(10);
      chk("cfg_err_sticky", 32'(cfg_err), 32'(1));

      chk("scoreboard_drained", 32'(sb.size()), 32'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/cpu_result_checker.md
Name: cpu_result_checker

Overview:
- Synthesizable, parametrised self-checker for the 16-bit multicycle/pipelined CPU; sits beside the cpu under test and watches its debug outputs (num_inst, output_port, is_halted).
- Holds a loadable table of (expected instruction count, expected WWD value) entries and checks each entry exactly once, in order.
- Tracks pass, fail and missed counts, enforces a cycle budget, and produces a latched summary.
- Replaces the behavioural, loop-over-all-tests bench checker so the same checking runs on FPGA and in regression.

Parameters:
- WORD_SIZE, 16: width of num_inst, output_port and table fields.
- NUM_TEST, 56: table depth (entries).
- IDX_W, 6: index/count width; must satisfy 2^IDX_W >= NUM_TEST+1.
- CYC_W, 16: cycle counter width.
- MAX_CYCLES, 10000: cycle budget in RUN; timeout when reached.
- STOP_ON_FAIL, 1: 1 = end the run at the first mismatch; 0 = keep checking.

Ports:
- clk, input, 1: clock, rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- load_valid, input, 1: table write request (IDLE only).
- load_inst, input, WORD_SIZE: expected num_inst for the entry.
- load_ans, input, WORD_SIZE: expected output_port for the entry.
- load_ready, output, 1: high when state==IDLE and entries<NUM_TEST.
- start, input, 1: begin a run (from IDLE or DONE).
- num_inst, input, WORD_SIZE: from cpu.
- output_port, input, WORD_SIZE: from cpu.
- is_halted, input, 1: from cpu.
- busy, output, 1: state==RUN.
- done, output, 1: state==DONE.
- done_cause, output, 2: 00 all checked, 01 halted, 10 timeout, 11 fail-stop.
- all_pass, output, 1: done && fail_cnt==0 && pass_cnt==entries && entries!=0.
- pass_cnt, output, IDX_W: entries that passed.
- fail_cnt, output, IDX_W: entries that failed.
- miss_cnt, output, IDX_W: entries skipped.
- first_fail_vld, output, 1: a failure has occurred this run.
- first_fail_idx, output, IDX_W: index of the first failing entry.
- cycle_cnt, output, CYC_W: RUN cycles elapsed; saturating.
- cfg_err, output, 1: sticky; a non-ascending load was rejected.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, entries=0, rd_ptr=0; all outputs 0 except load_ready=1. Reset mid-RUN aborts the run and clears the table.
- Table load, IDLE only: each load_valid&&load_ready cycle writes entry[entries] and increments entries.
  - load_inst must be strictly greater than the previous entry's inst. Otherwise the entry is dropped, entries is unchanged and cfg_err is set to 1 (cleared only by reset).
  - load_valid is ignored outside IDLE.
- start in IDLE or DONE: next cycle enters RUN. Clears rd_ptr, all counters, cycle_cnt, first_fail_*, done_cause. The table is kept.
  - If entries==0, go to DONE instead with cause 00 and all_pass=0.
  - start during RUN is ignored.
- RUN, every cycle:
  - cycle_cnt++ (saturates at 2^CYC_W-1). Let E=entry[rd_ptr].
  - num_inst==E.inst: if output_port==E.ans then pass_cnt++, else fail_cnt++ (and record first_fail if first_fail_vld=0). rd_ptr++.
  - num_inst>E.inst (unsigned): miss_cnt++, rd_ptr++. At most one entry is retired per cycle.
  - num_inst<E.inst: no action.
- RUN termination, evaluated after the same cycle's compare. Priority: fail-stop (STOP_ON_FAIL=1 and fail this cycle) > all checked (rd_ptr reaches entries) > is_halted==1 > cycle_cnt+1==MAX_CYCLES (timeout).
  - DONE latches done_cause.
  - Unchecked entries at halt or timeout are not counted in any counter.
- DONE: all outputs hold until start or reset.
- Latency: an entry retires in the cycle num_inst is sampled equal to or past it. Counters are visible one cycle later.

Optional Feature:
- Macro: CPU_RESULT_CHECKER_TRACE_EN.
- Defined: adds outputs first_fail_got[WORD_SIZE], first_fail_exp[WORD_SIZE] and first_fail_inst[WORD_SIZE]. They latch the observed output_port, the expected answer and num_inst at the first failure. They reset to 0 and clear on start.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Load (3,0),(5,0),(11,1); drive num_inst 0..11 with matching output_port, one step per cycle -> done_cause=00, pass_cnt=3, all_pass=1.
- Same table, output_port=2 at num_inst=5, STOP_ON_FAIL=1 -> done_cause=11, fail_cnt=1, first_fail_idx=1, pass_cnt=1; with TRACE_EN, first_fail_got=0x0002, first_fail_exp=0x0000, first_fail_inst=0x0005.
- num_inst jumps 3->12 in one cycle -> entries 1 and 2 retire as misses on consecutive cycles, miss_cnt=2, all_pass=0.
- Load 5 then 5 -> second load rejected, cfg_err=1, entries=1. Then start with num_inst stuck at 0, MAX_CYCLES=20 -> done_cause=10 after 20 RUN cycles.
- is_halted=1 at num_inst=5 with table (3,0),(5,0),(11,1), all matching -> done_cause=01, pass_cnt=2, all_pass=0.
- Assert reset_n=0 mid-RUN -> immediate IDLE, entries=0, all counters 0, load_ready=1.
